rng_collector: RTL and testbench

//   Consumer end of the ring-oscillator TRNG bit stream. Drives the generator's enable, takes

---
 rtl/rng_pkg.sv | 16 +
 rtl/rng_health_rct.sv | 48 ++++
 rtl/rng_collector.sv | 169 ++++++++++++++++
 tb/tb_rng_collector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared state type and default sizing for the TRNG collector
package rng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAIL    = 3'd4
  } rng_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_WARMUP     = 64;
  localparam int DEF_RCT_CUTOFF = 32;

endpackage

// File: rtl/rng_health_rct.sv
// rtl/rng_health_rct.sv - repetition-count health test on the raw bit stream
// fail_o is combinational: it flags the sample that completes a run of CUTOFF identical bits.
module rng_health_rct #(
  parameter int CUTOFF = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic raw_bit_i,
  input  logic raw_valid_i,
  output logic fail_o
);

  localparam int CW = $clog2(CUTOFF + 1);

  logic [CW-1:0] run_q, run_d;
  logic          last_q, last_d;

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    fail_o = 1'b0;
    if (clear_i) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (raw_valid_i) begin
      last_d = raw_bit_i;
      // run_q == 0 means no sample seen since clear, so the first bit starts a run
      if (run_q == '0 || raw_bit_i != last_q) begin
        run_d = CW'(1);
      end else if (run_q != CW'(CUTOFF)) begin
        run_d = run_q + CW'(1);
      end
      fail_o = (run_d == CW'(CUTOFF));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rng_collector.sv
// rtl/rng_collector.sv - TRNG collector: warm-up, RCT health test, word packing
// Optional von Neumann debiasing of collected bits when RNG_VON_NEUMANN_EN is defined.
module rng_collector
  import rng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int WARMUP     = DEF_WARMUP,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              osc_enable,
  input  logic              raw_bit,
  input  logic              raw_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail
);

  localparam int WW = $clog2(WARMUP + 1);
  localparam int BW = $clog2(WORD_W + 1);

  rng_state_e        state_q, state_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              osc_q, osc_d;
  logic              fail_q, fail_d;
  logic              acc, acc_bit;
  logic              rct_clear, rct_fail;
`ifdef RNG_VON_NEUMANN_EN
  logic              phase_q, phase_d;
  logic              first_q, first_d;
`endif

  assign rct_clear = !enable || state_q == ST_IDLE || state_q == ST_FAIL;

  rng_health_rct #(.CUTOFF(RCT_CUTOFF)) u_rct (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (rct_clear),
    .raw_bit_i  (raw_bit),
    .raw_valid_i(raw_valid),
    .fail_o     (rct_fail)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    fail_d  = fail_q;
    acc     = 1'b0;
    acc_bit = raw_bit;
`ifdef RNG_VON_NEUMANN_EN
    phase_d = phase_q;
    first_d = first_q;
`endif
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_WARMUP;
        warm_d  = '0;
      end
    end else if (state_q == ST_FAIL) begin
      state_d = ST_FAIL;
    end else if (!enable) begin
      state_d = ST_IDLE;
      warm_d  = '0;
      bits_d  = '0;
      shreg_d = '0;
      word_d  = '0;
      valid_d = 1'b0;
    end else if (rct_fail) begin
      // a coincident handshake still completes; the word just never reappears
      state_d = ST_FAIL;
      word_d  = '0;
      valid_d = 1'b0;
      fail_d  = 1'b1;
    end else if (state_q == ST_WARMUP) begin
      if (raw_valid) begin
        if (warm_q == WW'(WARMUP - 1)) begin
          state_d = ST_COLLECT;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WW'(1);
        end
      end
    end else if (state_q == ST_COLLECT) begin
`ifdef RNG_VON_NEUMANN_EN
      if (raw_valid) begin
        if (!phase_q) begin
          phase_d = 1'b1;
          first_d = raw_bit;
        end else begin
          phase_d = 1'b0;
          acc     = (first_q != raw_bit);
          acc_bit = first_q;
        end
      end
`else
      acc = raw_valid;
`endif
      if (acc) begin
        shreg_d = {shreg_q[WORD_W-2:0], acc_bit};
        if (bits_q == BW'(WORD_W - 1)) begin
          word_d  = {shreg_q[WORD_W-2:0], acc_bit};
          valid_d = 1'b1;
          bits_d  = '0;
          state_d = ST_HOLD;
        end else begin
          bits_d = bits_q + BW'(1);
        end
      end
    end else if (state_q == ST_HOLD) begin
      if (valid_q && word_ready) begin
        valid_d = 1'b0;
        state_d = ST_COLLECT;
      end
    end else begin
      state_d = ST_IDLE;
    end
`ifdef RNG_VON_NEUMANN_EN
    if (state_d == ST_COLLECT && state_q != ST_COLLECT) phase_d = 1'b0;
`endif
    osc_d = (state_d == ST_WARMUP || state_d == ST_COLLECT || state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      osc_q   <= 1'b0;
      fail_q  <= 1'b0;
`ifdef RNG_VON_NEUMANN_EN
      phase_q <= 1'b0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      osc_q   <= osc_d;
      fail_q  <= fail_d;
`ifdef RNG_VON_NEUMANN_EN
      phase_q <= phase_d;
      first_q <= first_d;
`endif
    end
  end

  assign osc_enable  = osc_q;
  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_rng_collector.sv
// tb/tb_rng_collector.sv - directed scoreboard bench for rng_collector (both RNG_VON_NEUMANN_EN builds)
module tb_rng_collector;

  localparam int WORD_W = 32;
  localparam int WARMUP = 64;
`ifdef RNG_VON_NEUMANN_EN
  localparam int F = 2;
  localparam logic [31:0] W1 = 32'hFFFF_FFFF;
`else
  localparam int F = 1;
  localparam logic [31:0] W1 = 32'h5555_5555;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic raw_bit = 1'b0, raw_valid = 1'b0, word_ready = 1'b0;
  logic osc_enable, word_valid, health_fail;
  logic [WORD_W-1:0] word_out;

  rng_collector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .osc_enable(osc_enable),
    .raw_bit(raw_bit), .raw_valid(raw_valid), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  int mode = 0, m_warm = 0, m_cnt = 0, n;
  logic [31:0] m_sh = '0, w;
  logic m_phase = 1'b0, m_first = 1'b0, tog;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic x);
    m_sh = {m_sh[30:0], x};
    m_cnt++;
    if (m_cnt == WORD_W) begin
      exp_q.push_back(m_sh);
      m_cnt = 0;
      mode = 3;
    end
  endtask

  task automatic feed(input logic b);
    raw_bit = b; raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
    if (mode == 1) begin
      m_warm++;
      if (m_warm == WARMUP) begin mode = 2; m_phase = 1'b0; end
    end else if (mode == 2) begin
`ifdef RNG_VON_NEUMANN_EN
      if (!m_phase) begin m_phase = 1'b1; m_first = b; end
      else begin m_phase = 1'b0; if (m_first != b) accept(m_first); end
`else
      accept(b);
`endif
    end
  endtask

  task automatic feed_alt();
    feed(tog);
    tog = ~tog;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    mode = 1; m_warm = 0; m_cnt = 0; m_sh = '0; m_phase = 1'b0;
  endtask

  task automatic ack();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    mode = 2; m_phase = 1'b0;
  endtask

  task automatic run_to_word(output int cnt);
    cnt = 0;
    while (word_valid !== 1'b1 && cnt < 400) begin
      feed_alt();
      cnt++;
    end
  endtask

  task automatic check_pop(input string tag);
    check({tag, "_qsize"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check(tag, word_out, exp_q.pop_front());
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", word_valid, 0);
    check("arst_word", word_out, 0);
    check("arst_osc", osc_enable, 0);
    check("arst_fail", health_fail, 0);
    #2 rst_n = 1'b1;
    enable = 1'b0; mode = 0; exp_q.delete();
  endtask

  initial begin
`ifdef RNG_VON_NEUMANN_EN
    tog = 1'b1;
`else
    tog = 1'b0;
`endif
    tick(); tick();
    check("rst_osc", osc_enable, 0);
    check("rst_valid", word_valid, 0);
    check("rst_word", word_out, 0);
    check("rst_fail", health_fail, 0);
    rst_n = 1'b1;
    tick();
    check("idle_osc", osc_enable, 0);

    // first word after warm-up plus one word of accepted bits
    start();
    check("t1_osc", osc_enable, 1);
    run_to_word(n);
    check("t1_latency", n, WARMUP + WORD_W * F);
    check("t1_valid", word_valid, 1);
    check("t1_const", word_out, W1);
    check_pop("t1_word");

    // back-pressure: word held through 100 cycles of HOLD traffic
    for (int i = 1; i <= 100; i++) begin
      feed_alt();
      if (i % 25 == 0) begin
        check("t2_hold_valid", word_valid, 1);
        check("t2_hold_word", word_out, W1);
      end
    end
    ack();
    check("t2_drop", word_valid, 0);
    run_to_word(n);
    check("t2_latency", n, WORD_W * F);
    check_pop("t2_word");

    // repetition count in HOLD: 31 ones tolerated, 32nd fails
    feed(1'b0);
    for (int i = 0; i < 31; i++) feed(1'b1);
    check("t3_nofail", health_fail, 0);
    check("t3_still_valid", word_valid, 1);
    feed(1'b1);
    mode = 0;
    check("t3_fail", health_fail, 1);
    check("t3_valid", word_valid, 0);
    check("t3_osc", osc_enable, 0);
    check("t3_word", word_out, 0);
    exp_q.delete();
    enable = 1'b0;
    tick(); tick();
    check("t3_sticky", health_fail, 1);
    async_reset();

    // enable dropped mid-collection discards partial word and warm-up
    start();
    for (int i = 0; i < WARMUP + 10 * F; i++) feed_alt();
    enable = 1'b0;
    tick();
    mode = 0;
    check("t4_idle_osc", osc_enable, 0);
    check("t4_idle_valid", word_valid, 0);
    start();
    check("t4_reen_osc", osc_enable, 1);
    run_to_word(n);
    check("t4_latency", n, WARMUP + WORD_W * F);
    check_pop("t4_word");

    // asynchronous reset while holding a word
    async_reset();

    // debias pattern 00,11,01,10 (plain build accepts all eight bits)
    start();
    for (int i = 0; i < WARMUP; i++) feed_alt();
    begin
      logic [7:0] pat;
      pat = 8'b0011_0110;
      for (int i = 7; i >= 0; i--) feed(pat[i]);
    end
    run_to_word(n);
`ifdef RNG_VON_NEUMANN_EN
    check("t6_latency", n, 60);
    w = word_out;
    check("t6_first_bits", {30'd0, w[31:30]}, 2'b01);
`else
    check("t6_latency", n, 24);
    w = word_out;
    check("t6_first_bits", {24'd0, w[31:24]}, 8'h36);
`endif
    check_pop("t6_word");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
